// File: rtl/soc_xbar_pkg.sv
// Shared definitions for the lite crossbar: target FSM encodings,
// index-width helper and the address-range decode function.
package soc_xbar_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_DEAD = 2'd3;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Inclusive unsigned range check; callers zero-extend to 64 bits.
  function automatic logic addr_hit(input logic [63:0] addr,
                                    input logic [63:0] lo,
                                    input logic [63:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/soc_xbar_tgt_port.sv
// One target port: round-robin arbiter over decoded initiators, request
// latch, IDLE/REQ/RESP/DEAD sequencer and response timeout counter.
module soc_xbar_tgt_port
  import soc_xbar_pkg::*;
#(
  parameter int NB_INIT        = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int BW = DATA_WIDTH / 8,
  localparam int OW = idx_w(NB_INIT)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NB_INIT-1:0]                   req,
  input  logic [NB_INIT-1:0][ADDR_WIDTH-1:0]   addr,
  input  logic [NB_INIT-1:0]                   we,
  input  logic [NB_INIT-1:0][BW-1:0]           be,
  input  logic [NB_INIT-1:0][DATA_WIDTH-1:0]   wdata,
  output logic [NB_INIT-1:0]                   gnt,
  output logic                                 tgt_req,
  output logic [ADDR_WIDTH-1:0]                tgt_addr,
  output logic                                 tgt_we,
  output logic [BW-1:0]                        tgt_be,
  output logic [DATA_WIDTH-1:0]                tgt_wdata,
  input  logic                                 tgt_gnt,
  input  logic                                 tgt_rvalid,
  input  logic [DATA_WIDTH-1:0]                tgt_rdata,
  input  logic                                 tgt_err,
  output logic                                 rsp_valid,
  output logic [OW-1:0]                        rsp_owner,
  output logic [DATA_WIDTH-1:0]                rsp_rdata,
  output logic                                 rsp_err,
  output logic                                 dead
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [1:0]    state;
  logic [OW-1:0] rr_ptr, owner, win;
  logic          found, timeout;
  logic [CW-1:0] cnt;

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NB_INIT; k++) begin
      int j;
      j = int'(rr_ptr) + k;
      if (j >= NB_INIT) j = j - NB_INIT;
      if (!found && req[j]) begin
        found = 1'b1;
        win   = OW'(j);
      end
    end
  end

  assign gnt     = (state == ST_IDLE && found) ? (NB_INIT'(1) << win) : '0;
  assign timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign tgt_req = (state == ST_REQ);
  assign dead    = (state == ST_DEAD);

  // A real response in the timeout cycle takes priority over the timeout.
  assign rsp_valid = (state == ST_RESP) && (tgt_rvalid || timeout);
  assign rsp_owner = owner;
  assign rsp_rdata = tgt_rvalid ? tgt_rdata : '0;
  assign rsp_err   = tgt_rvalid ? tgt_err : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      cnt       <= '0;
      tgt_addr  <= '0;
      tgt_we    <= 1'b0;
      tgt_be    <= '0;
      tgt_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: if (found) begin
          owner     <= win;
          rr_ptr    <= (win == OW'(NB_INIT - 1)) ? '0 : win + 1'b1;
          tgt_addr  <= addr[win];
          tgt_we    <= we[win];
          tgt_be    <= be[win];
          tgt_wdata <= wdata[win];
          state     <= ST_REQ;
        end
        ST_REQ: if (tgt_gnt) begin
          cnt   <= '0;
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (tgt_rvalid)   state <= ST_IDLE;
          else if (timeout) state <= ST_DEAD;
          else              cnt   <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/soc_xbar_lite.sv
// NB_INIT x NB_TGT request/response crossbar: address decode, decode-error
// responder, per-target ports and registered per-initiator response merge.
module soc_xbar_lite
  import soc_xbar_pkg::*;
#(
  parameter int NB_INIT        = 3,
  parameter int NB_TGT         = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter logic [NB_TGT*ADDR_WIDTH-1:0] START_ADDR =
    {32'h1A10_0000, 32'h0010_0000, 32'h0000_0000},
  parameter logic [NB_TGT*ADDR_WIDTH-1:0] END_ADDR =
    {32'h1A11_FFFF, 32'h001F_FFFF, 32'h000F_FFFF}
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NB_INIT-1:0]               init_req_i,
  input  logic [NB_INIT*ADDR_WIDTH-1:0]    init_addr_i,
  input  logic [NB_INIT-1:0]               init_we_i,
  input  logic [NB_INIT*DATA_WIDTH/8-1:0]  init_be_i,
  input  logic [NB_INIT*DATA_WIDTH-1:0]    init_wdata_i,
  output logic [NB_INIT-1:0]               init_gnt_o,
  output logic [NB_INIT-1:0]               init_rvalid_o,
  output logic [NB_INIT*DATA_WIDTH-1:0]    init_rdata_o,
  output logic [NB_INIT-1:0]               init_err_o,
  output logic [NB_TGT-1:0]                tgt_req_o,
  output logic [NB_TGT*ADDR_WIDTH-1:0]     tgt_addr_o,
  output logic [NB_TGT-1:0]                tgt_we_o,
  output logic [NB_TGT*DATA_WIDTH/8-1:0]   tgt_be_o,
  output logic [NB_TGT*DATA_WIDTH-1:0]     tgt_wdata_o,
  input  logic [NB_TGT-1:0]                tgt_gnt_i,
  input  logic [NB_TGT-1:0]                tgt_rvalid_i,
  input  logic [NB_TGT*DATA_WIDTH-1:0]     tgt_rdata_i,
  input  logic [NB_TGT-1:0]                tgt_err_i,
  output logic [NB_TGT-1:0]                tgt_dead_o
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int OW = idx_w(NB_INIT);
  localparam int TW = idx_w(NB_TGT);

  logic [NB_INIT-1:0]                 hit, dec_err, gnt_all;
  logic [NB_INIT-1:0][TW-1:0]         sel;
  logic [NB_TGT-1:0][NB_INIT-1:0]     preq, pgnt;
  logic [NB_TGT-1:0]                  prsp_v, prsp_er;
  logic [NB_TGT-1:0][OW-1:0]          prsp_own;
  logic [NB_TGT-1:0][DATA_WIDTH-1:0]  prsp_rd;
  logic [NB_INIT-1:0]                 rv_d, er_d;
  logic [NB_INIT-1:0][DATA_WIDTH-1:0] rd_d;

  // Scan high to low so the lowest-index overlapping region wins.
  always_comb begin
    for (int i = 0; i < NB_INIT; i++) begin
      hit[i] = 1'b0;
      sel[i] = '0;
      for (int t = NB_TGT - 1; t >= 0; t--) begin
        if (addr_hit(64'(init_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH]),
                     64'(START_ADDR[t*ADDR_WIDTH +: ADDR_WIDTH]),
                     64'(END_ADDR[t*ADDR_WIDTH +: ADDR_WIDTH]))) begin
          hit[i] = 1'b1;
          sel[i] = TW'(t);
        end
      end
      dec_err[i] = init_req_i[i] & (~hit[i] | tgt_dead_o[sel[i]]);
    end
  end

  always_comb begin
    for (int t = 0; t < NB_TGT; t++)
      for (int i = 0; i < NB_INIT; i++)
        preq[t][i] = init_req_i[i] & hit[i] & (sel[i] == TW'(t)) & ~tgt_dead_o[t];
  end

  always_comb begin
    gnt_all = dec_err;
    for (int t = 0; t < NB_TGT; t++) gnt_all = gnt_all | pgnt[t];
  end
  assign init_gnt_o = rst ? '0 : gnt_all;

  for (genvar t = 0; t < NB_TGT; t++) begin : g_tgt
    soc_xbar_tgt_port #(
      .NB_INIT        (NB_INIT),
      .ADDR_WIDTH     (ADDR_WIDTH),
      .DATA_WIDTH     (DATA_WIDTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_port (
      .clk        (clk),
      .rst        (rst),
      .req        (preq[t]),
      .addr       (init_addr_i),
      .we         (init_we_i),
      .be         (init_be_i),
      .wdata      (init_wdata_i),
      .gnt        (pgnt[t]),
      .tgt_req    (tgt_req_o[t]),
      .tgt_addr   (tgt_addr_o[t*ADDR_WIDTH +: ADDR_WIDTH]),
      .tgt_we     (tgt_we_o[t]),
      .tgt_be     (tgt_be_o[t*BW +: BW]),
      .tgt_wdata  (tgt_wdata_o[t*DATA_WIDTH +: DATA_WIDTH]),
      .tgt_gnt    (tgt_gnt_i[t]),
      .tgt_rvalid (tgt_rvalid_i[t]),
      .tgt_rdata  (tgt_rdata_i[t*DATA_WIDTH +: DATA_WIDTH]),
      .tgt_err    (tgt_err_i[t]),
      .rsp_valid  (prsp_v[t]),
      .rsp_owner  (prsp_own[t]),
      .rsp_rdata  (prsp_rd[t]),
      .rsp_err    (prsp_er[t]),
      .dead       (tgt_dead_o[t])
    );
  end

  // One-outstanding rule guarantees at most one source per initiator.
  always_comb begin
    for (int i = 0; i < NB_INIT; i++) begin
      rv_d[i] = dec_err[i];
      er_d[i] = dec_err[i];
      rd_d[i] = '0;
      for (int t = 0; t < NB_TGT; t++) begin
        if (prsp_v[t] && prsp_own[t] == OW'(i)) begin
          rv_d[i] = 1'b1;
          er_d[i] = er_d[i] | prsp_er[t];
          rd_d[i] = rd_d[i] | prsp_rd[t];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_rvalid_o <= '0;
      init_err_o    <= '0;
      init_rdata_o  <= '0;
    end else begin
      init_rvalid_o <= rv_d;
      init_err_o    <= er_d;
      init_rdata_o  <= rd_d;
    end
  end

endmodule
